// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/size/burst encodings, master FSM states and the alignment rule.
// Pure declarations; no latency or flow control of its own.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        MST_IDLE,
        MST_ADDR,
        MST_DATA,
        MST_RESP
    } mst_state_t;

    // Natural alignment of a transfer; sizes above a dword are never aligned.
    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
        case (size)
            HSIZE_BYTE:  return 1'b1;
            HSIZE_HALF:  return ~addr_lo[0];
            HSIZE_WORD:  return addr_lo[1:0] == 2'b00;
            HSIZE_DWORD: return addr_lo == 3'b000;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Address to one-hot hsel decoder over the top log2(NUM_SLAVES) address bits.
// Combinational, zero latency; no flow control.
module ahb_addr_decode #(
    parameter int ADDR_W     = 32,
    parameter int NUM_SLAVES = 4
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [NUM_SLAVES-1:0] hsel_o
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic [SEL_W-1:0] idx;
    logic             unused_low;

    assign idx        = addr_i[ADDR_W-1 -: SEL_W];
    assign unused_low = ^addr_i[ADDR_W-SEL_W-1:0];

    // A select field past NUM_SLAVES (non power-of-two count) selects nothing.
    always_comb begin
        hsel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hsel_o[i] = (NUM_SLAVES == 1) || (int'(idx) == i);
        end
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: one NONSEQ per request, rsp_valid 3 cycles after accept (+1 per wait state).
// Backpressure: req_ready low from accept until the cycle after the response strobe.
module ahb_lite_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_size,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DATA_W-1:0]     hwdata,
    output logic [NUM_SLAVES-1:0] hsel,
    input  logic [DATA_W-1:0]     hrdata,
    input  logic                  hready,
    input  logic                  hresp
);
    import ahb_pkg::*;

    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mst_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_seen_q, err_seen_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_to_q, rsp_to_d;
    logic                req_ok;
    logic                bus_err;
    logic [NUM_SLAVES-1:0] dec_sel;

    ahb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .addr_i (addr_q),
        .hsel_o (dec_sel)
    );

    assign req_ok  = is_aligned(req_addr[2:0], req_size) && (int'(req_size) <= MAX_SIZE);
    // An ERROR in the first (hready low) cycle must still fail the transfer.
    assign bus_err = hresp | err_seen_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        err_seen_d  = err_seen_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            MST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    write_d = req_write;
                    if (req_ok) begin
                        state_d = MST_ADDR;
                    end else begin
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b0;
                        state_d   = MST_RESP;
                    end
                end
            end
            MST_ADDR: state_d = MST_DATA;
            MST_DATA: begin
                if (hresp) err_seen_d = 1'b1;
                if (hready) begin
                    rsp_err_d = bus_err;
                    rsp_to_d  = 1'b0;
                    if (!write_q && !bus_err) rsp_rdata_d = hrdata;
                    state_d = MST_RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        rsp_err_d = 1'b1;
                        rsp_to_d  = 1'b1;
                        state_d   = MST_RESP;
                    end
                end
            end
            MST_RESP: begin
                cnt_d      = '0;
                err_seen_d = 1'b0;
                state_d    = MST_IDLE;
            end
            default: state_d = MST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= MST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            err_seen_q  <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            err_seen_q  <= err_seen_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign req_ready   = (state_q == MST_IDLE);
    assign rsp_valid   = (state_q == MST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

    assign htrans = (state_q == MST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsel   = (state_q == MST_ADDR || state_q == MST_DATA) ? dec_sel : '0;
    assign haddr  = addr_q;
    assign hwrite = write_q;
    assign hsize  = size_q;
    assign hburst = HBURST_SINGLE;
    assign hwdata = (state_q == MST_DATA && write_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed plus randomized bench for ahb_lite_master with a reactive AHB slave and a transaction-level model.
module tb_ahb_lite_master;

    localparam int TIMEOUT = 16;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hsel;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    ahb_lite_master #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .NUM_SLAVES (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hwdata      (hwdata),
        .hsel        (hsel),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 64'(htrans), 0);
        chk({tag, "_hsel"}, 64'(hsel), 0);
        chk({tag, "_haddr"}, 64'(haddr), 0);
        chk({tag, "_hwrite"}, 64'(hwrite), 0);
        chk({tag, "_hsize"}, 64'(hsize), 0);
        chk({tag, "_hwdata"}, 64'(hwdata), 0);
        chk({tag, "_hburst"}, 64'(hburst), 0);
        chk({tag, "_req_ready"}, 64'(req_ready), 1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
    endtask

    // One request end to end. Starts and ends just after a falling edge.
    // waits: data-phase cycles with hready low before the slave completes;
    // serr: slave answers with a two-cycle ERROR (needs waits >= 1).
    task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input int waits, input bit serr,
                           input logic [31:0] rdata);
        bit          ok, to_exp, err_exp, in_data, seen;
        int          lat_exp, nonseq, d;
        logic [3:0]  sel_exp;
        logic [31:0] rdata_exp;

        ok        = (size <= 3'd2) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
        sel_exp   = 4'b0001 << addr[31:30];
        to_exp    = ok && (waits >= TIMEOUT);
        err_exp   = !ok || to_exp || serr;
        lat_exp   = !ok ? 1 : (to_exp ? 2 + TIMEOUT : 3 + waits);
        rdata_exp = (ok && !wr && !err_exp) ? rdata : exp_rdata;

        chk("req_ready_idle", 64'(req_ready), 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        hready    = 1'b1;
        hresp     = 1'b0;
        @(posedge hclk);

        nonseq = 0; in_data = 0; d = 0; seen = 0;
        for (int t = 1; t <= TIMEOUT + 12 && !seen; t++) begin
            @(negedge hclk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_write = 1'($urandom_range(0, 1));
            req_size  = 3'($urandom_range(0, 7));
            if (t == 1) chk("req_ready_busy", 64'(req_ready), 0);
            if (rsp_valid) begin
                seen = 1;
                chk("rsp_latency", 64'(t), 64'(lat_exp));
                chk("rsp_err", 64'(rsp_err), 64'(err_exp));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(to_exp));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(rdata_exp));
                chk("resp_hsel", 64'(hsel), 0);
                hready = 1'b1;
                hresp  = 1'b0;
            end else if (in_data) begin
                chk("data_htrans", 64'(htrans), 0);
                chk("data_hsel", 64'(hsel), 64'(sel_exp));
                chk("data_haddr", 64'(haddr), 64'(addr));
                chk("data_hwdata", 64'(hwdata), wr ? 64'(wdata) : 64'(0));
                if (d >= waits && !to_exp) begin
                    hready  = 1'b1;
                    hresp   = serr;
                    hrdata  = rdata;
                    in_data = 0;
                end else begin
                    hready = 1'b0;
                    hresp  = serr && (d == waits - 1);
                    hrdata = $urandom;
                end
                d++;
            end else if (htrans == 2'b10) begin
                nonseq++;
                chk("addr_phase_cycle", 64'(t), 1);
                chk("addr_hsel", 64'(hsel), 64'(sel_exp));
                chk("addr_haddr", 64'(haddr), 64'(addr));
                chk("addr_hwrite", 64'(hwrite), 64'(wr));
                chk("addr_hsize", 64'(hsize), 64'(size));
                // Noise on hready/hresp during the address phase must be ignored.
                hready  = 1'($urandom_range(0, 1));
                hresp   = 1'($urandom_range(0, 1));
                hrdata  = $urandom;
                in_data = 1;
            end else begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
        end

        if (!seen) begin
            chk("rsp_seen", 0, 1);
        end else begin
            @(negedge hclk);
            chk("post_rsp_valid", 64'(rsp_valid), 0);
            chk("post_req_ready", 64'(req_ready), 1);
            chk("post_hsel", 64'(hsel), 0);
            chk("post_htrans", 64'(htrans), 0);
            chk("post_rsp_err_held", 64'(rsp_err), 64'(err_exp));
            chk("post_rsp_rdata_held", 64'(rsp_rdata), 64'(rdata_exp));
        end
        chk("nonseq_count", 64'(nonseq), ok ? 64'(1) : 64'(0));
        hready = 1'b1;
        hresp  = 1'b0;
        exp_rdata = rdata_exp;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          w, r;
        bit          se;

        repeat (3) @(negedge hclk);
        chk_reset_outputs("reset");
        hreset = 1'b0;
        @(negedge hclk);

        run_req(1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 3'd2, 0, 1'b0, 32'h0);
        run_req(1'b0, 32'hC000_0010, 32'h0, 3'd2, 2, 1'b0, 32'h1234_5678);
        run_req(1'b0, 32'h8000_0000, 32'h0, 3'd2, 1, 1'b1, 32'h5555_AAAA);
        run_req(1'b1, 32'h0000_0000, 32'h1111_2222, 3'd2, 16, 1'b0, 32'h0);
        run_req(1'b1, 32'h0000_0002, 32'h3333_4444, 3'd2, 0, 1'b0, 32'h0);
        run_req(1'b0, 32'h4000_0002, 32'h0, 3'd1, 15, 1'b0, 32'hCAFE_F00D);
        run_req(1'b0, 32'h8000_0001, 32'h0, 3'd1, 0, 1'b0, 32'h0BAD_0BAD);
        run_req(1'b0, 32'h0000_0000, 32'h0, 3'd3, 0, 1'b0, 32'h0BAD_0BAD);
        run_req(1'b0, 32'hC000_0003, 32'h0, 3'd0, 0, 1'b0, 32'h0000_00A5);
        run_req(1'b0, 32'h4000_0000, 32'h0, 3'd2, 3, 1'b1, 32'h0BAD_0BAD);

        // Reset during a wait state: outputs clear immediately, no response follows.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0008; req_size = 3'd2;
        @(negedge hclk);
        req_valid = 1'b0;
        hready    = 1'b0;
        repeat (3) @(negedge hclk);
        #2 hreset = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        repeat (2) begin
            @(negedge hclk);
            chk("in_reset_rsp_valid", 64'(rsp_valid), 0);
        end
        hready    = 1'b1;
        hreset    = 1'b0;
        exp_rdata = '0;
        repeat (2) begin
            @(negedge hclk);
            chk("after_reset_rsp_valid", 64'(rsp_valid), 0);
        end
        run_req(1'b0, 32'h8000_0020, 32'h0, 3'd2, 1, 1'b0, 32'h7777_8888);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            r  = int'($urandom_range(0, 9));
            w  = (r < 7) ? int'($urandom_range(0, 3)) :
                 (r < 9) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 17));
            se = (w > 0) && (w < TIMEOUT) && ($urandom_range(0, 3) == 0);
            run_req(1'($urandom_range(0, 1)), a, $urandom, sz, w, se, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
